req_arbiter: RTL and testbench

- Four-requester arbiter that shares one downstream resource.
- Fixed-priority mode: requester 3 has the highest priority and requester 0 the lowest.
- Round-robin mode: rotating priority.
- A granted owner keeps the grant until it drops its request or a hold-time limit expires. The arbiter then sits idle for one cycle and re-arbitrates.
- Sits between the request sources and the shared datapath; drives the one-hot grant and the encoded grant index with a valid flag.

---
 rtl/req_arbiter.sv | 157 +++++++++++++++
 tb/tb_req_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : req_arbiter
//  Purpose  : Four-requester arbiter for one shared downstream resource.
//             Fixed priority (3 highest) or rotating round-robin priority.
//             An owner keeps the grant until it drops its request or the
//             hold limit expires; every release is followed by one idle
//             cycle before re-arbitration.
//  Ports    : clk       - clock, rising edge
//             rst       - synchronous active-high reset
//             req[3:0]  - request vector, bit i = requester i
//             rr_en     - 1 = round-robin, 0 = fixed priority (used in IDLE)
//             gnt[3:0]  - registered one-hot grant
//             gnt_id    - registered encoded grant index
//             gnt_valid - high while a grant is held
//             timeout   - one-cycle pulse when the hold limit revokes a grant
//  Revision : 1.0 - initial release
// ============================================================================
module req_arbiter #(
    parameter int MAX_HOLD = 8,   // max consecutive grant cycles, 0 = no limit
    parameter int CNT_W    = 4    // hold counter width, 2**CNT_W > MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rr_en,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // With no hold limit the counter never advances and expiry never fires.
    localparam logic             C_HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q,     state_d;
    logic [3:0]       gnt_q,       gnt_d;
    logic [1:0]       gnt_id_q,    gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q,   timeout_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [1:0]       last_id_q,   last_id_d;

    // ------------------------------------------------------------------
    // Winner selection. Both modes search downward starting one below a
    // base index and finishing on the base itself. Fixed mode uses base 0,
    // which yields the order 3,2,1,0; round-robin uses the last owner, so
    // the previous owner is considered last and a lone requester still wins.
    // ------------------------------------------------------------------
    logic [1:0] w_search_base;
    logic [1:0] w_cand;
    logic [1:0] w_win_id;
    logic       w_win_found;

    always_comb begin
        w_search_base = rr_en ? last_id_q : 2'b00;
        w_cand        = 2'b00;
        w_win_id      = 2'b00;
        w_win_found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = w_search_base - k[1:0];
            if (!w_win_found && req[w_cand]) begin
                w_win_id    = w_cand;
                w_win_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;

        case (state_q)
            S_IDLE: begin
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
                if (|req) begin
                    state_d     = S_GRANT;
                    gnt_d       = 4'b0001 << w_win_id;
                    gnt_id_d    = w_win_id;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end

            S_GRANT: begin
                // Voluntary release is checked before expiry so that a
                // requester dropping on its last cycle gets no timeout pulse.
                // Other requesters are ignored here: no preemption.
                if (!req[gnt_id_q]) begin
                    state_d     = S_IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    last_id_d   = gnt_id_q;
                end else if (C_HOLD_EN && (hold_cnt_q == C_HOLD_LAST)) begin
                    state_d     = S_IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    last_id_d   = gnt_id_q;
                    timeout_d   = 1'b1;
                end else if (C_HOLD_EN) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'b00;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_id_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_req_arbiter
//  Purpose  : Self-checking bench for req_arbiter. Directed scenarios are
//             followed by randomized request/mode/reset traffic. A reference
//             model tracks ownership in terms of "who owns, for how many
//             cycles, who owned last" and queues the expected outputs after
//             every clock edge; a separate monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_req_arbiter;

    localparam int MAX_HOLD = 8;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       rr_en;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    req_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   run_done = 1'b0;

    // ------------------------------------------------------------------
    // Reference model: owner index (-1 = nobody), cycles owned so far,
    // previous owner, and the last reported grant index.
    // ------------------------------------------------------------------
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    int m_id    = 0;
    bit m_to    = 1'b0;

    // Candidates are visited from the one just below 'start' going down,
    // wrapping, and the start index itself comes last.
    function automatic int pick_winner(input logic [3:0] r, input int start);
        int order[4];
        for (int k = 0; k < 4; k++) order[k] = (start + 3 - k) % 4;
        for (int k = 0; k < 4; k++) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!run_done) begin
            m_to = 1'b0;
            if (rst) begin
                m_owner = -1; m_held = 0; m_last = 0; m_id = 0;
            end else if (m_owner < 0) begin
                if (req != 4'b0000) begin
                    m_owner = pick_winner(req, rr_en ? m_last : 0);
                    m_id    = m_owner;
                    m_held  = 1;
                end
            end else if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
            e.gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            e.id    = 2'(m_id);
            e.valid = (m_owner >= 0);
            e.to    = m_to;
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one output set per clock edge, sampled 1 time unit later.
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!run_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
            end else begin
                e = exp_q.pop_front();
                check("gnt",       gnt,              e.gnt);
                check("gnt_id",    {2'b00, gnt_id},  {2'b00, e.id});
                check("gnt_valid", {3'b000, gnt_valid}, {3'b000, e.valid});
                check("timeout",   {3'b000, timeout},   {3'b000, e.to});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: values change on the falling edge only.
    // ------------------------------------------------------------------
    task automatic cyc(input logic [3:0] r, input logic m, input logic rs, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req   = r;
            rr_en = m;
            rst   = rs;
        end
    endtask

    initial begin
        logic [3:0] r_req;
        logic       r_rr;
        rst   = 1'b1;
        req   = 4'b0000;
        rr_en = 1'b0;

        // reset, then idle
        cyc(4'b0000, 1'b0, 1'b1, 2);
        cyc(4'b0000, 1'b0, 1'b0, 5);
        // fixed priority, no preemption by a higher requester
        cyc(4'b0101, 1'b0, 1'b0, 2);
        cyc(4'b1101, 1'b0, 1'b0, 2);
        cyc(4'b1001, 1'b0, 1'b0, 4);
        cyc(4'b0000, 1'b0, 1'b0, 2);
        // hold-limit expiry and re-grant of the same requester
        cyc(4'b0010, 1'b0, 1'b0, 22);
        cyc(4'b0000, 1'b0, 1'b0, 2);
        // round-robin rotation with everybody requesting
        cyc(4'b1111, 1'b1, 1'b0, 50);
        cyc(4'b0000, 1'b1, 1'b0, 2);
        // lone requester equal to the previous owner
        cyc(4'b0100, 1'b1, 1'b0, 3);
        cyc(4'b0000, 1'b1, 1'b0, 2);
        cyc(4'b0100, 1'b1, 1'b0, 3);
        cyc(4'b0000, 1'b1, 1'b0, 2);
        // reset during a grant, then re-arbitration from a clean last owner
        cyc(4'b1111, 1'b1, 1'b0, 3);
        cyc(4'b0000, 1'b1, 1'b0, 2);
        cyc(4'b0010, 1'b0, 1'b0, 4);
        cyc(4'b0010, 1'b0, 1'b1, 1);
        cyc(4'b0010, 1'b1, 1'b0, 4);
        cyc(4'b0000, 1'b0, 1'b0, 2);

        // randomized traffic: sticky requests, occasional mode flips and resets
        r_req = 4'b0000;
        r_rr  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r_req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) r_rr  = ~r_rr;
            cyc(r_req, r_rr, ($urandom_range(0, 149) == 0), 1);
        end
        cyc(4'b0000, 1'b0, 1'b0, 3);

        @(posedge clk);
        #3;
        run_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
